// File: rtl/ras_ckpt.sv
// Return-address stack for the frontend branch predictor.
// Circular buffer of RASDepth entries (any depth >= 2) that wraps and
// overwrites the oldest entry on overflow, plus a single-slot
// checkpoint/restore that repairs the stack after a mispredicted speculative
// call or return without flushing it.
module ras_ckpt #(
    parameter int RASDepth = 2,
    parameter int VLEN     = 64,
    parameter int PtrW     = $clog2(RASDepth),
    parameter int CntW     = $clog2(RASDepth + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic [VLEN-1:0] data_i,
    input  logic            ckpt_save_i,
    input  logic            ckpt_restore_i,
    output logic [VLEN-1:0] data_o,
    output logic            valid_o,
    output logic [CntW-1:0] count_o,
    output logic            overflow_o,
    output logic            underflow_o,
    output logic            ckpt_valid_o
);

    localparam logic [PtrW-1:0] LastPtr = PtrW'(RASDepth - 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(RASDepth);
    localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    // Stack storage and top-of-stack state
    logic [VLEN-1:0] entries_q [RASDepth];
    logic [VLEN-1:0] entries_d [RASDepth];
    logic [PtrW-1:0] ptr_q, ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    // Snapshot slot
    logic [PtrW-1:0] sptr_q, sptr_d;
    logic [CntW-1:0] scnt_q, scnt_d;
    logic [VLEN-1:0] sdata_q, sdata_d;
    logic            svalid_q, svalid_d;

    // Registered status pulses
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;

    // Single write port into the entry array
    logic            wr_en;
    logic [PtrW-1:0] wr_idx;
    logic [VLEN-1:0] wr_data;

    logic [PtrW-1:0] ptr_inc;
    logic [PtrW-1:0] ptr_dec;
    logic [VLEN-1:0] top_data;

    // Wrapping pointer neighbours; explicit compares keep non-power-of-two depths correct
    always_comb begin
        ptr_inc  = (ptr_q == LastPtr) ? '0 : ptr_q + PtrOne;
        ptr_dec  = (ptr_q == '0) ? LastPtr : ptr_q - PtrOne;
        top_data = entries_q[ptr_q];
    end

    // Next-state selection: flush beats restore beats push/pop; save rides along with push/pop only
    always_comb begin
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        sptr_d   = sptr_q;
        scnt_d   = scnt_q;
        sdata_d  = sdata_q;
        svalid_d = svalid_q;
        ovf_d    = 1'b0;
        unf_d    = 1'b0;
        wr_en    = 1'b0;
        wr_idx   = ptr_q;
        wr_data  = data_i;

        if (flush_i) begin
            // Entry contents are left alone; only the bookkeeping is cleared
            ptr_d    = '0;
            cnt_d    = '0;
            svalid_d = 1'b0;
        end else if (ckpt_restore_i) begin
            if (svalid_q) begin
                ptr_d   = sptr_q;
                cnt_d   = scnt_q;
                wr_en   = 1'b1;
                wr_idx  = sptr_q;
                wr_data = sdata_q;
            end
        end else begin
            // Snapshot captures the state as it was before this cycle's push/pop
            if (ckpt_save_i) begin
                sptr_d   = ptr_q;
                scnt_d   = cnt_q;
                sdata_d  = top_data;
                svalid_d = 1'b1;
            end

            if (push_i && pop_i) begin
                // Return followed by a call: replace the top entry in place
                wr_en  = 1'b1;
                wr_idx = ptr_q;
                cnt_d  = (cnt_q == '0) ? CntOne : cnt_q;
            end else if (push_i) begin
                wr_en  = 1'b1;
                wr_idx = ptr_inc;
                ptr_d  = ptr_inc;
                if (cnt_q < FullCnt) begin
                    cnt_d = cnt_q + CntOne;
                end else begin
                    ovf_d = 1'b1;
                end
            end else if (pop_i) begin
                if (cnt_q != '0) begin
                    ptr_d = ptr_dec;
                    cnt_d = cnt_q - CntOne;
                end else begin
                    unf_d = 1'b1;
                end
            end
        end
    end

    // Entry array next values from the single write port
    always_comb begin
        for (int i = 0; i < RASDepth; i++) begin
            entries_d[i] = (wr_en && (wr_idx == PtrW'(i))) ? wr_data : entries_q[i];
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < RASDepth; i++) begin
                entries_q[i] <= '0;
            end
            ptr_q    <= '0;
            cnt_q    <= '0;
            sptr_q   <= '0;
            scnt_q   <= '0;
            sdata_q  <= '0;
            svalid_q <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            for (int i = 0; i < RASDepth; i++) begin
                entries_q[i] <= entries_d[i];
            end
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            sptr_q   <= sptr_d;
            scnt_q   <= scnt_d;
            sdata_q  <= sdata_d;
            svalid_q <= svalid_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Outputs are straight from registers
    always_comb begin
        data_o       = top_data;
        valid_o      = (cnt_q != '0);
        count_o      = cnt_q;
        overflow_o   = ovf_q;
        underflow_o  = unf_q;
        ckpt_valid_o = svalid_q;
    end

endmodule

// File: tb/tb_ras_ckpt.sv
// Scoreboard bench for ras_ckpt: a driver applies directed then random
// operations and pushes the reference model's expected outputs into a
// queue; a monitor pops and compares one entry per clock.
module tb_ras_ckpt;

    localparam int D    = 3;
    localparam int VLEN = 64;
    localparam int CW   = $clog2(D + 1);

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            flush = 1'b0, push = 1'b0, pop = 1'b0, save = 1'b0, restore = 1'b0;
    logic [VLEN-1:0] din = '0;
    logic [VLEN-1:0] data_o;
    logic            valid_o, overflow_o, underflow_o, ckpt_valid_o;
    logic [CW-1:0]   count_o;

    ras_ckpt #(.RASDepth(D), .VLEN(VLEN)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .push_i(push), .pop_i(pop),
        .data_i(din), .ckpt_save_i(save), .ckpt_restore_i(restore),
        .data_o(data_o), .valid_o(valid_o), .count_o(count_o),
        .overflow_o(overflow_o), .underflow_o(underflow_o), .ckpt_valid_o(ckpt_valid_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [VLEN-1:0] data;
        logic            valid;
        logic [CW-1:0]   cnt;
        logic            ovf;
        logic            unf;
        logic            cv;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   txn    = 0;

    // Reference model: a ring of slots, a top index and an occupancy count
    logic [VLEN-1:0] m_mem [D];
    int              m_top, m_cnt;
    int              s_top, s_cnt;
    logic [VLEN-1:0] s_data;
    bit              s_valid;
    bit              m_ovf, m_unf;

    task automatic model_reset();
        for (int i = 0; i < D; i++) m_mem[i] = '0;
        m_top = 0; m_cnt = 0; s_top = 0; s_cnt = 0; s_data = '0; s_valid = 0;
        m_ovf = 0; m_unf = 0;
    endtask

    task automatic model_step(input bit f, input bit r, input bit s, input bit pu,
                              input bit po, input logic [VLEN-1:0] d);
        m_ovf = 0; m_unf = 0;
        if (f) begin
            m_top = 0; m_cnt = 0; s_valid = 0;
        end else if (r) begin
            if (s_valid) begin
                m_top = s_top; m_cnt = s_cnt; m_mem[s_top] = s_data;
            end
        end else begin
            if (s) begin
                s_top = m_top; s_cnt = m_cnt; s_data = m_mem[m_top]; s_valid = 1;
            end
            if (pu && po) begin
                m_mem[m_top] = d;
                if (m_cnt < 1) m_cnt = 1;
            end else if (pu) begin
                m_top = (m_top + 1) % D;
                m_mem[m_top] = d;
                if (m_cnt < D) m_cnt++;
                else m_ovf = 1;
            end else if (po) begin
                if (m_cnt > 0) begin
                    m_top = (m_top + D - 1) % D;
                    m_cnt--;
                end else begin
                    m_unf = 1;
                end
            end
        end
    endtask

    function automatic obs_t model_obs();
        obs_t o;
        o.data  = m_mem[m_top];
        o.valid = (m_cnt != 0);
        o.cnt   = CW'(m_cnt);
        o.ovf   = m_ovf;
        o.unf   = m_unf;
        o.cv    = s_valid;
        return o;
    endfunction

    // Drive one cycle of stimulus and queue its expected result
    task automatic step(input bit f, input bit r, input bit s, input bit pu,
                        input bit po, input logic [VLEN-1:0] d);
        @(negedge clk);
        flush = f; restore = r; save = s; push = pu; pop = po; din = d;
        model_step(f, r, s, pu, po, d);
        exp_q.push_back(model_obs());
        @(posedge clk);
    endtask

    // Monitor: compare DUT outputs 1 time unit after every rising edge
    always @(posedge clk) begin
        obs_t e, a;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            a = '{data: data_o, valid: valid_o, cnt: count_o, ovf: overflow_o,
                  unf: underflow_o, cv: ckpt_valid_o};
            checks++;
            txn++;
            if (a !== e) begin
                errors++;
                $display("FAIL txn%0d: got data=%h valid=%b cnt=%0d ovf=%b unf=%b cv=%b, expected data=%h valid=%b cnt=%0d ovf=%b unf=%b cv=%b",
                         txn, a.data, a.valid, a.cnt, a.ovf, a.unf, a.cv,
                         e.data, e.valid, e.cnt, e.ovf, e.unf, e.cv);
            end else begin
                $display("txn%0d ok: data=%h valid=%b cnt=%0d ovf=%b unf=%b cv=%b",
                         txn, a.data, a.valid, a.cnt, a.ovf, a.unf, a.cv);
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    localparam logic [VLEN-1:0] A = 64'hA0A0, B = 64'hB0B0, C = 64'hC0C0, DD = 64'hD0D0;
    localparam logic [VLEN-1:0] X = 64'hEEEE;

    initial begin
        logic [VLEN-1:0] rd;
        int unsigned     sel;
        model_reset();
        rst = 1'b1;
        #12;
        // Reset state
        checks++;
        if ({data_o, valid_o, count_o, overflow_o, underflow_o, ckpt_valid_o} !== '0) begin
            errors++;
            $display("FAIL reset_state: got data=%h cnt=%0d valid=%b, expected all zero",
                     data_o, count_o, valid_o);
        end else $display("reset_state ok");
        @(negedge clk);
        rst = 1'b0;

        // Single push then pop
        step(0, 0, 0, 1, 0, 64'h1000);
        step(0, 0, 0, 0, 1, '0);
        // Overflow and underflow on a depth-3 stack
        step(0, 0, 0, 1, 0, A);
        step(0, 0, 0, 1, 0, B);
        step(0, 0, 0, 1, 0, C);
        step(0, 0, 0, 1, 0, DD);
        step(0, 0, 0, 0, 0, '0);
        step(0, 0, 0, 0, 1, '0);
        step(0, 0, 0, 0, 1, '0);
        step(0, 0, 0, 0, 1, '0);
        step(0, 0, 0, 0, 1, '0);
        step(0, 0, 0, 0, 0, '0);
        // Push+pop replaces top; push+pop on empty gives count 1
        step(0, 0, 0, 1, 0, A);
        step(0, 0, 0, 1, 1, 64'h2000);
        step(1, 0, 0, 0, 0, '0);
        step(0, 0, 0, 1, 1, 64'h3000);
        // Checkpoint save alongside a push, speculative damage, restore
        step(1, 0, 0, 0, 0, '0);
        step(0, 0, 0, 1, 0, A);
        step(0, 0, 0, 1, 0, B);
        step(0, 0, 1, 1, 0, C);
        step(0, 0, 0, 0, 1, '0);
        step(0, 0, 0, 0, 1, '0);
        step(0, 0, 0, 1, 0, X);
        step(0, 1, 0, 0, 0, '0);
        step(0, 0, 0, 0, 1, '0);
        // Restore with a push in the same cycle; push ignored
        step(0, 1, 0, 1, 0, X);
        // Flush with push and save; restore afterwards does nothing
        step(0, 0, 0, 1, 0, A);
        step(0, 0, 1, 0, 0, '0);
        step(1, 0, 1, 1, 0, B);
        step(0, 1, 0, 0, 0, '0);
        step(0, 1, 0, 1, 1, C);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            bit f, r, s, pu, po;
            rd  = {$urandom, $urandom};
            sel = $urandom_range(0, 99);
            f   = (sel < 3);
            r   = (sel >= 3 && sel < 12);
            s   = ($urandom_range(0, 99) < 15);
            pu  = ($urandom_range(0, 99) < 50);
            po  = ($urandom_range(0, 99) < 45);
            step(f, r, s, pu, po, rd);
        end

        // Asynchronous reset mid-stream, then verify first push lands after release
        step(0, 0, 0, 1, 0, A);
        step(0, 0, 1, 1, 0, B);
        @(negedge clk);
        push = 1'b0; pop = 1'b0; save = 1'b0; restore = 1'b0; flush = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({data_o, valid_o, count_o, overflow_o, underflow_o, ckpt_valid_o} !== '0) begin
            errors++;
            $display("FAIL async_reset: got data=%h cnt=%0d valid=%b cv=%b, expected all zero",
                     data_o, count_o, valid_o, ckpt_valid_o);
        end else $display("async_reset ok");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step(0, 0, 0, 1, 0, C);
        step(0, 0, 0, 0, 1, '0);
        step(0, 0, 0, 0, 0, '0);

        // Drain: every queued expectation must have been consumed
        for (int w = 0; w < 10 && exp_q.size() != 0; w++) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
